// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NREQ producers, bounded bursts.
// Optional per-requester saturating ack counters are built when ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    input  logic [CW-1:0]      fifo_count,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_data,
    output logic               busy
`ifdef ARB_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [NREQ*8-1:0]  stat_cnt
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [PW-1:0]        last_ptr_q, last_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 busy_q, busy_d;
    logic [NREQ-1:0]      ack_c;
    logic                 space_c;
    logic                 win_found_c;
    logic [PW-1:0]        win_idx_c;
    logic [NREQ-1:0][DW-1:0] rd_c;

    assign rd_c = req_data;

    // A write issued last edge is not yet visible in fifo_count, so count it as occupied.
    assign space_c = (({1'b0, fifo_count} + (CW+1)'(wr_en_q)) < (CW+1)'(DEPTH));

    // Scan from last_ptr+1 upward; descending loop leaves the nearest requester as winner.
    always_comb begin
        logic [PW-1:0] cand;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand        = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = PW'((int'(last_ptr_q) + k) % int'(NREQ));
            if (req[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        busy_d     = busy_q;
        ack_c      = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_c && space_c) begin
                    state_d    = ST_BURST;
                    grant_d    = NREQ'(1) << win_idx_c;
                    last_ptr_d = win_idx_c;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_BURST: begin
                if (req[last_ptr_q] && space_c) begin
                    ack_c[last_ptr_q] = 1'b1;
                    wr_en_d           = 1'b1;
                    data_d            = rd_c[last_ptr_q];
                    beat_cnt_d        = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == BW'(BURST - 1)) begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                        beat_cnt_d = '0;
                    end
                end else if (!req[last_ptr_q]) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_ptr_q <= PW'(NREQ - 1);
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign ack        = ack_c;
    assign grant      = grant_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_data  = data_q;
    assign busy       = busy_q;

`ifdef ARB_STATS_EN
    logic [NREQ-1:0][7:0] stat_q, stat_d;

    // Clear has priority over a same-cycle ack; counters stick at 255.
    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (stat_clr) begin
                stat_d[i] = 8'd0;
            end else if (ack_c[i] && (stat_q[i] != 8'hFF)) begin
                stat_d[i] = stat_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 8-deep, 8-bit synchronous FIFO write port among NREQ producers.
- Grants one producer at a time for a bounded burst of words.
- Drives the FIFO's wr_en/data_in from registered outputs and throttles itself from the FIFO's fifo_count, so a write is never issued into a full FIFO.
- Sits directly in front of the sync FIFO; the read side of the FIFO is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width, matches the FIFO data_in
- DEPTH, 8, FIFO depth, matches the FIFO full threshold
- CW, 4, fifo_count width (must represent DEPTH)
- BURST, 4, max words accepted per grant (1..16)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- req  in  NREQ  per-requester write request; held with valid data until acked
- req_data  in  NREQ*DW  requester i data on bits [i*DW +: DW]
- ack  out  NREQ  combinational; ack[i]=1 means req_data[i] is taken at this edge
- grant  out  NREQ  registered one-hot current owner; all-zero in IDLE
- fifo_count  in  CW  FIFO occupancy
- fifo_wr_en  out  1  registered write strobe to the FIFO
- fifo_data  out  DW  registered write data to the FIFO
- busy  out  1  registered; 1 while in BURST

Behaviour:
- Reset (rst=0 at an edge), regardless of state:
  - grant=0, fifo_wr_en=0, fifo_data=0, busy=0, state=IDLE, beat_cnt=0.
  - last_ptr=NREQ-1, so requester 0 wins first.
- Space check:
  - space = (fifo_count + fifo_wr_en) < DEPTH, computed at CW+1 bits.
  - fifo_wr_en is added because a write issued this cycle is not yet reflected in fifo_count.
  - Reads in flight are ignored (conservative).
- FSM IDLE:
  - If any req and space: winner = first asserted req scanning last_ptr+1, +2, ... modulo NREQ.
  - Next edge: grant=onehot(winner), last_ptr=winner, beat_cnt=0, busy=1, state=BURST.
  - No ack in IDLE. One arbitration bubble cycle per grant.
- FSM BURST, owner g:
  - ack[g] = req[g] & space; all other ack bits are 0.
  - On ack: fifo_data<=req_data[g], fifo_wr_en<=1, beat_cnt++. Otherwise fifo_wr_en<=0.
  - Exit to IDLE (grant<=0, busy<=0) on:
    - ack with beat_cnt==BURST-1; or
    - req[g]==0, with no ack that cycle.
  - !space with req[g]=1: stall; hold grant and beat_cnt, keep fifo_wr_en=0. No timeout.
- Latency: one cycle from ack edge to fifo_wr_en. Data written to the FIFO equals req_data at the ack edge.
- fifo_data holds its last value when fifo_wr_en=0.
- Fairness: after g's burst, g is lowest priority. With all requesters asserting, the grant order is 0,1,...,NREQ-1,0,...
- Requester contract: a requester must not change req_data[i] while req[i]=1 and ack[i]=0. Dropping req mid-burst is legal and ends the burst.
- fifo_count==DEPTH with fifo_wr_en=0: no grant is issued from IDLE; in BURST the grant stalls.
- Reset asserted mid-burst: the in-flight registered write is dropped (fifo_wr_en=0 next cycle).

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output port stat_cnt (NREQ*8 bits); requester i occupies [i*8 +: 8].
  - Each counter is an 8-bit saturating count of acks, cleared by reset, sticking at 255.
  - Adds input port stat_clr (1 bit), a synchronous clear of all counters. If stat_clr and an ack occur in the same cycle, the clear wins.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then req=4'b0001 with data 0x11,0x22,0x33,0x44,0x55 and fifo_count=0:
  - Grant to 0 after one bubble cycle; 4 acks in consecutive cycles; fifo_wr_en 4 cycles carrying 0x11..0x44.
  - Back to IDLE, re-grant to 0, then 0x55.
- req=4'b1111 held, fifo_count=0 (mock read drains): grant sequence 0,1,2,3,0; each burst is 4 words; ack is never asserted for a non-owner.
- fifo_count=7 with fifo_wr_en=0, owner 2 requesting:
  - One ack; the next cycle space=0, so ack=0 and the grant stalls.
  - Drop fifo_count to 6: ack resumes; the total never exceeds DEPTH.
- Owner 1 drops req after 2 words: IDLE next edge, busy=0; the pending req3 wins the next arbitration.
- rst=0 asserted mid-burst with a write pending: next cycle grant=0, fifo_wr_en=0, busy=0. After release, req=4'b1010 is granted to 1 first.
- ARB_STATS_EN defined:
  - 300 acks to requester 0: stat_cnt[7:0]=255.
  - Pulse stat_clr alongside an ack: counter reads 0.
